// File: rtl/core_defines.sv
// Shared core constants: opcodes, ALU control codes, issue-stage state encoding
// and the registered issue payload.
package core_defines;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_PASS_B = 6'b010000;
  localparam logic [2:0] ALU_BR_PFX = 3'b100;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} issue_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        is_branch;
    logic [5:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic        illegal;
  } issue_pkt_t;
endpackage

// File: rtl/d_decode.sv
// Combinational decode of a fetch beat into ALU operands, control and immediate.
module d_decode
  import core_defines::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [31:0] imm,
  output logic [5:0]  alu_ctrl,
  output logic        is_branch,
  output logic        illegal
);
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, i_imm, u_imm, b_imm;

  assign funct3  = instr[14:12];
  // x0 always reads as zero, whatever the register file returns
  assign rs1_val = (instr[19:15] == 5'd0) ? 32'h0 : rs1_data;
  assign rs2_val = (instr[24:20] == 5'd0) ? 32'h0 : rs2_data;
  assign i_imm   = {{20{instr[31]}}, instr[31:20]};
  assign u_imm   = {instr[31:12], 12'h0};
  assign b_imm   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    operand_a = 32'h0;
    operand_b = 32'h0;
    imm       = 32'h0;
    alu_ctrl  = ALU_ADD;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        operand_a = rs1_val;
        operand_b = rs2_val;
        alu_ctrl  = {2'b00, instr[30], funct3};
      end
      OPC_OP_IMM: begin
        operand_a = rs1_val;
        operand_b = i_imm;
        imm       = i_imm;
        // bit 30 only selects SRAI; elsewhere it is immediate data
        alu_ctrl  = {2'b00, (funct3 == 3'b101) & instr[30], funct3};
      end
      OPC_LUI: begin
        operand_b = u_imm;
        imm       = u_imm;
        alu_ctrl  = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        operand_a = pc;
        operand_b = u_imm;
        imm       = u_imm;
      end
      OPC_BRANCH: begin
        operand_a = rs1_val;
        operand_b = rs2_val;
        imm       = b_imm;
        alu_ctrl  = {ALU_BR_PFX, funct3};
        is_branch = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/d_issue.sv
// One-entry decode/issue stage between fetch and execute.
// Optional D_ISSUE_PERF_EN adds issued/stall/flush event counters.
module d_issue
  import core_defines::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        a_valid,
  input  logic        a_ready,
  input  logic        br_en,
  output logic [31:0] a_pc,
  output logic        is_branch,
  output logic [5:0]  ALU_Control,
  output logic [31:0] operand_A,
  output logic [31:0] operand_B,
  output logic [31:0] imm,
  output logic        illegal
`ifdef D_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);
  issue_state_t state, state_nxt;
  issue_pkt_t   pkt_q, dec_pkt;
  logic         capture, handshake, flush, load;

  assign rs1_addr = f_instr[19:15];
  assign rs2_addr = f_instr[24:20];

  d_decode u_dec (
    .instr     (f_instr),
    .pc        (f_pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .operand_a (dec_pkt.op_a),
    .operand_b (dec_pkt.op_b),
    .imm       (dec_pkt.imm),
    .alu_ctrl  (dec_pkt.alu_ctrl),
    .is_branch (dec_pkt.is_branch),
    .illegal   (dec_pkt.illegal)
  );
  assign dec_pkt.pc = f_pc;

  assign a_valid   = (state == ST_FULL);
  assign f_ready   = (state == ST_EMPTY) | a_ready;
  assign capture   = f_valid & f_ready;
  assign handshake = a_valid & a_ready;
  // a taken branch squashes the wrong-path beat arriving alongside it
  assign flush     = handshake & br_en;
  assign load      = capture & ~flush;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (capture) state_nxt = ST_FULL;
      ST_FULL:  if (handshake) state_nxt = load ? ST_FULL : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_EMPTY;
      pkt_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) pkt_q <= dec_pkt;
    end
  end

  assign a_pc        = pkt_q.pc;
  assign is_branch   = pkt_q.is_branch;
  assign ALU_Control = pkt_q.alu_ctrl;
  assign operand_A   = pkt_q.op_a;
  assign operand_B   = pkt_q.op_b;
  assign imm         = pkt_q.imm;
  assign illegal     = pkt_q.illegal;

`ifdef D_ISSUE_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_flush  <= '0;
    end else begin
      if (handshake)           perf_issued <= perf_issued + 32'd1;
      if (a_valid && !a_ready) perf_stall  <= perf_stall + 32'd1;
      if (flush)               perf_flush  <= perf_flush + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_d_issue.sv
// Self-checking bench for d_issue: directed scenarios then randomized traffic
// against a transaction-level model of the stage.
module tb_d_issue;
  logic        clock = 1'b0;
  logic        reset, f_valid, a_ready, br_en;
  logic [31:0] f_pc, f_instr, rs1_data, rs2_data;
  logic        f_ready, a_valid, is_branch, illegal;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] a_pc, operand_A, operand_B, imm;
  logic [5:0]  ALU_Control;
`ifdef D_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall, perf_flush;
`endif

  always #5 clock = ~clock;

  d_issue dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_ready(f_ready),
    .f_pc(f_pc), .f_instr(f_instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .a_valid(a_valid), .a_ready(a_ready),
    .br_en(br_en), .a_pc(a_pc), .is_branch(is_branch), .ALU_Control(ALU_Control),
    .operand_A(operand_A), .operand_B(operand_B), .imm(imm), .illegal(illegal)
`ifdef D_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  typedef struct {
    logic [31:0] pc, a, b, imm;
    logic [5:0]  alu;
    logic        br, ill;
  } exp_t;

  int   n_cmp = 0, n_err = 0;
  bit   m_full;
  exp_t m_e;
  int unsigned m_issued, m_stall, m_flush;

  function automatic exp_t zero_exp();
    exp_t e;
    e.pc = 0; e.a = 0; e.b = 0; e.imm = 0; e.alu = 0; e.br = 0; e.ill = 0;
    return e;
  endfunction

  // Reference decode from the instruction-set rules
  function automatic exp_t ref_dec(input logic [31:0] ins, pc, r1, r2);
    exp_t e = zero_exp();
    int f3 = int'(ins[14:12]);
    logic [31:0] v1 = (ins[19:15] == 0) ? 32'h0 : r1;
    logic [31:0] v2 = (ins[24:20] == 0) ? 32'h0 : r2;
    logic [11:0] i12 = ins[31:20];
    logic [12:0] b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic signed [31:0] iimm, bimm;
    logic [31:0] uimm = ins & 32'hFFFFF000;
    iimm = $signed(i12);
    bimm = $signed(b13);
    e.pc = pc;
    case (ins[6:0])
      7'h33: begin e.a = v1; e.b = v2; e.alu = 6'(int'(ins[30]) * 8 + f3); end
      7'h13: begin
        e.a = v1; e.b = iimm; e.imm = iimm;
        e.alu = 6'(((f3 == 5) ? int'(ins[30]) * 8 : 0) + f3);
      end
      7'h37: begin e.b = uimm; e.imm = uimm; e.alu = 6'd16; end
      7'h17: begin e.a = pc; e.b = uimm; e.imm = uimm; end
      7'h63: begin e.a = v1; e.b = v2; e.imm = bimm; e.alu = 6'(32 + f3); e.br = 1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check visible outputs mid-cycle, advance model and DUT
  task automatic cycle(input logic rst, fv, input logic [31:0] pc, ins, r1, r2,
                       input logic ar, br, input bit do_chk);
    bit cap, hs, fl;
    reset = rst; f_valid = fv; f_pc = pc; f_instr = ins;
    rs1_data = r1; rs2_data = r2; a_ready = ar; br_en = br;
    #3;
    if (do_chk) begin
      chk("a_valid", 32'(a_valid), 32'(m_full));
      chk("f_ready", 32'(f_ready), 32'(!m_full || ar));
      chk("rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
      chk("rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
      chk("a_pc", a_pc, m_e.pc);
      chk("operand_A", operand_A, m_e.a);
      chk("operand_B", operand_B, m_e.b);
      chk("imm", imm, m_e.imm);
      chk("ALU_Control", 32'(ALU_Control), 32'(m_e.alu));
      chk("is_branch", 32'(is_branch), 32'(m_e.br));
      chk("illegal", 32'(illegal), 32'(m_e.ill));
`ifdef D_ISSUE_PERF_EN
      chk("perf_issued", perf_issued, m_issued);
      chk("perf_stall", perf_stall, m_stall);
      chk("perf_flush", perf_flush, m_flush);
`endif
    end
    if (!rst) begin
      m_full = 0; m_e = zero_exp(); m_issued = 0; m_stall = 0; m_flush = 0;
    end else begin
      cap = fv && (!m_full || ar);
      hs  = m_full && ar;
      fl  = hs && br;
      if (hs) m_issued++;
      if (m_full && !ar) m_stall++;
      if (fl) m_flush++;
      if (fl) m_full = 0;
      else if (cap) begin m_full = 1; m_e = ref_dec(ins, pc, r1, r2); end
      else if (hs) m_full = 0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] ins = $urandom;
    case ($urandom_range(0, 5))
      0: ins[6:0] = 7'h33;
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h37;
      3: ins[6:0] = 7'h17;
      4: ins[6:0] = 7'h63;
      default: ins[6:0] = 7'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) ins[19:15] = 5'd0;
    if ($urandom_range(0, 3) == 0) ins[24:20] = 5'd0;
    return ins;
  endfunction

  initial begin
    m_full = 0; m_e = zero_exp(); m_issued = 0; m_stall = 0; m_flush = 0;
    // reset held for two cycles
    cycle(0, 1, 32'h40, 32'h002081B3, 32'h11, 32'h22, 1, 0, 0);
    cycle(0, 1, 32'h40, 32'h002081B3, 32'h11, 32'h22, 1, 0, 1);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_f_ready", 32'(f_ready), 1);
    chk("rst_alu", 32'(ALU_Control), 0);
    // add x3,x1,x2
    cycle(1, 1, 32'h0, 32'h002081B3, 32'd5, 32'd7, 1, 0, 1);
    chk("add_valid", 32'(a_valid), 1);
    chk("add_A", operand_A, 32'd5);
    chk("add_B", operand_B, 32'd7);
    chk("add_alu", 32'(ALU_Control), 32'h00);
    // addi x1,x0,-1 ignores rs1_data
    cycle(1, 1, 32'h4, 32'hFFF00093, 32'h1234, 32'h0, 1, 0, 1);
    chk("addi_A", operand_A, 32'h0);
    chk("addi_B", operand_B, 32'hFFFFFFFF);
    // back-pressure for three cycles while fetch keeps offering
    for (int i = 0; i < 3; i++)
      cycle(1, 1, 32'h8 + 32'(i * 4), rnd_instr(), $urandom, $urandom, 0, 1, 1);
    chk("stall_B", operand_B, 32'hFFFFFFFF);
    chk("stall_pc", a_pc, 32'h4);
`ifdef D_ISSUE_PERF_EN
    chk("stall_cnt", perf_stall, 32'd3);
`endif
    // beq at 0x100 taken; wrong-path beat at 0x104 is squashed
    cycle(1, 1, 32'h100, 32'h00208063, 32'h9, 32'h9, 1, 0, 1);
    chk("beq_branch", 32'(is_branch), 1);
    cycle(1, 1, 32'h104, 32'h00100093, 32'h0, 32'h0, 1, 1, 1);
    chk("flush_valid", 32'(a_valid), 0);
    cycle(1, 0, 32'h108, 32'h0, 32'h0, 32'h0, 1, 0, 1);
    chk("flush_still_empty", 32'(a_valid), 0);
    // unsupported opcode
    cycle(1, 1, 32'h200, 32'h0020807F, 32'h55, 32'h66, 1, 0, 1);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_alu", 32'(ALU_Control), 32'h00);
    chk("ill_A", operand_A, 32'h0);
    chk("ill_B", operand_B, 32'h0);
    // reset while full discards the held instruction
    cycle(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
    chk("rst_full_valid", 32'(a_valid), 0);
    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), $urandom,
            rnd_instr(), $urandom, $urandom, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 4) == 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
